pre_if_fetch_gen: RTL and testbench
===================================

// Module: pre_if_fetch_gen
// PURPOSE
//  Pre-IF stage: generates the next fetch PC and drives the instruction-side
//  request interface. It consumes cp0's exception/ERET redirect
//  (exception_like_now, exception_like_now_pc) and the ID-stage branch
//  redirect, with MIPS delay-slot ordering. Accepted fetches go to IF with a
//  cancel tag for wrong-path requests. A misaligned PC is sent to IF as AdEL
//  and is never issued to memory.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  first fetch address after reset release
// PORTS
//  clk                    in   1   clock, all state on rising edge
//  reset                  in   1   reset, ASYNCHRONOUS, ACTIVE-LOW
//  exception_like_now     in   1   cp0 redirect pulse (exception or ERET)
//  exception_like_now_pc  in   32  cp0 redirect target
//  br_valid               in   1   ID: taken branch/jump resolved, 1-cycle pulse
//  br_target              in   32  ID: branch target
//  br_ds_issued           in   1   ID: delay slot already accepted (addr_ok seen)
//  if_allowin             in   1   IF can take one more fetch
//  inst_req               out  1   request valid to I-side memory
//  inst_addr              out  32  request virtual address
//  inst_addr_ok           in   1   memory accepted request this cycle
//  to_if_valid            out  1   one fetch handed to IF this cycle
//  to_if_pc               out  32  PC of that fetch
//  to_if_cancel           out  1   fetch is wrong-path; IF discards its data
//  to_if_adel             out  1   fetch is misaligned (AdEL); no data follows
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; pc_r=RESET_PC; every pending flag=0;
//   inst_req=0, to_if_valid=0, to_if_cancel=0, to_if_adel=0 immediately.
//  Next-PC priority (IDLE, evaluated each cycle):
//   exception_like_now_pc > exc_pend_pc > br_pend_tgt (only if ds_done=1) > pc_r.
//  States:
//   IDLE: if if_allowin and fetch_pc[1:0]==0: inst_req=1, inst_addr=fetch_pc.
//     On inst_addr_ok in the same cycle: hand to IF, stay IDLE. Else go to REQ.
//     if if_allowin and fetch_pc[1:0]!=0: no request; to_if_valid=1,
//     to_if_adel=1, to_if_pc=fetch_pc; go to HALT.
//   REQ: inst_req=1. inst_addr is held constant until inst_addr_ok, even
//     if a redirect arrives. On inst_addr_ok: hand to IF, go to IDLE.
//   HALT: no requests. Leave to IDLE only on exception_like_now.
//  Hand-to-IF: to_if_valid=1 for exactly one cycle on the inst_addr_ok cycle.
//   to_if_pc=issued addr. pc_r <= issued addr + 4 (32-bit modulo wrap).
//   to_if_cancel=1 if a redirect was latched after this request was issued,
//   or exception_like_now=1 in the same cycle.
//  Exception: on exception_like_now, latch exc_pend_pc, clear any branch
//   pending, and set cancel-mark on any unaccepted request. In IDLE it is used
//   the same cycle (no latch needed). Cleared once its request is accepted.
//  Branch: on br_valid with no exception this cycle: br_pend=1,
//   br_pend_tgt=br_target, ds_done=br_ds_issued. If ds_done=0, the next
//   accepted fetch (the delay slot) is not cancelled and sets ds_done=1.
//   The following fetch uses br_pend_tgt. Fetches accepted after the delay
//   slot and before the target are cancelled. br_pend is cleared when the
//   target request is accepted.
//  Simultaneous exception + br_valid: exception wins, branch is discarded.
//  Redirect and inst_addr_ok in the same cycle: the accepted fetch is
//   cancelled (except a delay slot). The next request uses the new target.
//  IF guarantees to absorb any to_if_valid whose request was issued while
//   if_allowin=1. This block never drops or duplicates a handed-off fetch.
//  Latency: redirect in IDLE -> inst_addr=target same cycle. In REQ, it takes
//   effect the cycle after inst_addr_ok.
// TESTING
//  1 reset release, if_allowin=1, addr_ok each cycle -> inst_addr BFC00000,
//    BFC00004, BFC00008; to_if_valid each cycle, cancel=0.
//  2 REQ at 0x100 waiting 3 cycles; exception_like_now(pc=80000180) in cycle 1
//    -> inst_addr stays 0x100; on accept to_if_cancel=1; next req 80000180.
//  3 br_valid(target=0x400, ds_issued=0) after fetch 0x200 -> 0x204 uncancelled,
//    next fetch 0x400.
//  4 br_valid(target=0x400, ds_issued=1) with REQ 0x208 pending -> 0x208
//    cancel=1, then 0x400.
//  5 br_target=0x402 -> no inst_req; to_if_valid+to_if_adel with pc 0x402;
//    HALT until exception_like_now(80000180) -> req 80000180.
//  6 assert reset in REQ -> inst_req=0 immediately; after release fetch BFC00000.

Source files
------------

// File: rtl/pre_if_fetch_gen.sv
// Pre-IF stage: selects the next fetch PC, drives the I-side request port and hands
// accepted fetches to IF, tagging wrong-path fetches as cancelled and misaligned ones as AdEL.
module pre_if_fetch_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exception_like_now,
    input  logic [31:0] exception_like_now_pc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        br_ds_issued,
    input  logic        if_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    output logic        to_if_valid,
    output logic [31:0] to_if_pc,
    output logic        to_if_cancel,
    output logic        to_if_adel
);

    typedef enum logic [1:0] {StIdle, StReq, StHalt} state_e;
    // What an outstanding request stands for, so its acceptance retires the right pending item.
    typedef enum logic [1:0] {RoleSeq, RoleDs, RoleTgt, RoleExc} role_e;

    state_e      state_q, state_d;
    role_e       role_q, role_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        exc_pend_q, exc_pend_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_tgt_q, br_tgt_d;
    logic        ds_done_q, ds_done_d;
    logic        cancel_mark_q, cancel_mark_d;

    logic        br_take;
    logic        eff_br;
    logic        eff_ds_done;
    logic [31:0] eff_tgt;
    logic [31:0] fetch_pc;
    role_e       fetch_role;
    logic        cancel_now;
    logic        retire;

    // A branch seen while an exception is in flight belongs to a flushed path.
    assign br_take = br_valid & ~exception_like_now & ~exc_pend_q;

    always_comb begin
        eff_br      = ~exception_like_now & (br_take | br_pend_q);
        eff_tgt     = br_take ? br_target : br_tgt_q;
        eff_ds_done = br_take ? br_ds_issued : ds_done_q;

        if (exception_like_now) begin
            fetch_pc   = exception_like_now_pc;
            fetch_role = RoleExc;
        end else if (exc_pend_q) begin
            fetch_pc   = exc_pc_q;
            fetch_role = RoleExc;
        end else if (eff_br && eff_ds_done) begin
            fetch_pc   = eff_tgt;
            fetch_role = RoleTgt;
        end else begin
            fetch_pc   = pc_q;
            fetch_role = eff_br ? RoleDs : RoleSeq;
        end
    end

    always_comb begin
        state_d       = state_q;
        role_d        = role_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        exc_pend_d    = exc_pend_q;
        exc_pc_d      = exc_pc_q;
        br_pend_d     = br_pend_q;
        br_tgt_d      = br_tgt_q;
        ds_done_d     = ds_done_q;
        cancel_mark_d = cancel_mark_q;
        cancel_now    = 1'b0;
        retire        = 1'b0;

        inst_req      = 1'b0;
        inst_addr     = req_addr_q;
        to_if_valid   = 1'b0;
        to_if_pc      = req_addr_q;
        to_if_cancel  = 1'b0;
        to_if_adel    = 1'b0;

        case (state_q)
            StIdle: begin
                if (exception_like_now) begin
                    exc_pend_d = 1'b1;
                    exc_pc_d   = exception_like_now_pc;
                    br_pend_d  = 1'b0;
                end else begin
                    br_pend_d = eff_br;
                    br_tgt_d  = eff_tgt;
                    ds_done_d = eff_ds_done;
                end
                inst_addr = fetch_pc;
                to_if_pc  = fetch_pc;
                if (if_allowin) begin
                    if (fetch_pc[1:0] == 2'b00) begin
                        inst_req = 1'b1;
                        role_d   = fetch_role;
                        if (inst_addr_ok) begin
                            to_if_valid = 1'b1;
                            pc_d        = fetch_pc + 32'd4;
                            retire      = 1'b1;
                        end else begin
                            state_d       = StReq;
                            req_addr_d    = fetch_pc;
                            cancel_mark_d = 1'b0;
                        end
                    end else begin
                        // Misaligned: report AdEL and stop until cp0 redirects.
                        to_if_valid = 1'b1;
                        to_if_adel  = 1'b1;
                        exc_pend_d  = 1'b0;
                        br_pend_d   = 1'b0;
                        state_d     = StHalt;
                    end
                end
            end
            StReq: begin
                inst_req   = 1'b1;
                cancel_now = cancel_mark_q;
                if (exception_like_now) begin
                    exc_pend_d    = 1'b1;
                    exc_pc_d      = exception_like_now_pc;
                    br_pend_d     = 1'b0;
                    cancel_mark_d = 1'b1;
                    role_d        = RoleSeq;
                    cancel_now    = 1'b1;
                end else if (br_take) begin
                    br_pend_d = 1'b1;
                    br_tgt_d  = br_target;
                    ds_done_d = br_ds_issued;
                    if (br_ds_issued) begin
                        cancel_mark_d = 1'b1;
                        role_d        = RoleSeq;
                        cancel_now    = 1'b1;
                    end else if (!cancel_mark_q) begin
                        role_d = RoleDs;
                    end
                end
                if (inst_addr_ok) begin
                    to_if_valid   = 1'b1;
                    to_if_cancel  = cancel_now;
                    pc_d          = req_addr_q + 32'd4;
                    cancel_mark_d = 1'b0;
                    retire        = ~cancel_now;
                    state_d       = StIdle;
                end
            end
            StHalt: begin
                if (exception_like_now) begin
                    exc_pend_d = 1'b1;
                    exc_pc_d   = exception_like_now_pc;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (retire) begin
            case (role_d)
                RoleDs:  ds_done_d  = 1'b1;
                RoleTgt: br_pend_d  = 1'b0;
                RoleExc: exc_pend_d = 1'b0;
                default: ;
            endcase
        end

        // Reset silences the request and hand-off strobes without waiting for a clock.
        if (!reset) begin
            inst_req     = 1'b0;
            to_if_valid  = 1'b0;
            to_if_cancel = 1'b0;
            to_if_adel   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            role_q        <= RoleSeq;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            exc_pend_q    <= 1'b0;
            exc_pc_q      <= 32'h0;
            br_pend_q     <= 1'b0;
            br_tgt_q      <= 32'h0;
            ds_done_q     <= 1'b0;
            cancel_mark_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            role_q        <= role_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            exc_pend_q    <= exc_pend_d;
            exc_pc_q      <= exc_pc_d;
            br_pend_q     <= br_pend_d;
            br_tgt_q      <= br_tgt_d;
            ds_done_q     <= ds_done_d;
            cancel_mark_q <= cancel_mark_d;
        end
    end

endmodule

// File: tb/tb_pre_if_fetch_gen.sv
// Bench for pre_if_fetch_gen: directed redirect scenarios then randomized traffic, all
// checked each cycle against a transaction-level model of the fetch stream.
module tb_pre_if_fetch_gen;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        exception_like_now;
    logic [31:0] exception_like_now_pc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        br_ds_issued;
    logic        if_allowin;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        to_if_valid;
    logic [31:0] to_if_pc;
    logic        to_if_cancel;
    logic        to_if_adel;

    always #5 clk = ~clk;

    pre_if_fetch_gen #(.RESET_PC(RESET_PC)) dut (
        .clk                  (clk),
        .reset                (reset),
        .exception_like_now   (exception_like_now),
        .exception_like_now_pc(exception_like_now_pc),
        .br_valid             (br_valid),
        .br_target            (br_target),
        .br_ds_issued         (br_ds_issued),
        .if_allowin           (if_allowin),
        .inst_req             (inst_req),
        .inst_addr            (inst_addr),
        .inst_addr_ok         (inst_addr_ok),
        .to_if_valid          (to_if_valid),
        .to_if_pc             (to_if_pc),
        .to_if_cancel         (to_if_cancel),
        .to_if_adel           (to_if_adel)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Model: the stream of fetches seen as an outstanding request plus pending redirects.
    bit          m_halted, m_busy, m_out_wrong;
    int          m_out_kind; // 0 sequential, 1 delay slot, 2 branch target, 3 exception target
    logic [31:0] m_next, m_out_addr;
    bit          m_exc_on, m_br_on, m_slot_seen;
    logic [31:0] m_exc_pc, m_br_tgt;

    // Snapshot of DUT outputs from the last step, for directed constant checks.
    logic        s_req, s_v, s_cancel, s_adel;
    logic [31:0] s_addr, s_pc;

    task automatic model_reset();
        m_halted = 0; m_busy = 0; m_out_wrong = 0; m_out_kind = 0;
        m_next = RESET_PC; m_out_addr = RESET_PC;
        m_exc_on = 0; m_br_on = 0; m_slot_seen = 0;
        m_exc_pc = '0; m_br_tgt = '0;
    endtask

    task automatic m_retire(input int kind);
        if (kind == 1) m_slot_seen = 1;
        if (kind == 2) m_br_on = 0;
        if (kind == 3) m_exc_on = 0;
    endtask

    task automatic model_cycle();
        logic        e_req, e_v, e_cancel, e_adel, take_br;
        logic [31:0] e_addr, e_pc, a;
        int          k;
        e_req = 0; e_v = 0; e_cancel = 0; e_adel = 0; e_addr = '0; e_pc = '0;
        if (m_halted) begin
            if (exception_like_now) begin
                m_halted = 0; m_exc_on = 1; m_exc_pc = exception_like_now_pc;
            end
        end else begin
            take_br = br_valid && !exception_like_now && !m_exc_on;
            if (exception_like_now) begin
                m_exc_on = 1; m_exc_pc = exception_like_now_pc; m_br_on = 0;
                if (m_busy) begin m_out_wrong = 1; m_out_kind = 0; end
            end else if (take_br) begin
                m_br_on = 1; m_br_tgt = br_target; m_slot_seen = br_ds_issued;
                if (m_busy && br_ds_issued) begin
                    m_out_wrong = 1; m_out_kind = 0;
                end else if (m_busy && !m_out_wrong) begin
                    m_out_kind = 1;
                end
            end
            if (m_busy) begin
                e_req = 1; e_addr = m_out_addr;
                if (inst_addr_ok) begin
                    e_v = 1; e_pc = m_out_addr; e_cancel = m_out_wrong;
                    m_next = m_out_addr + 32'd4;
                    if (!m_out_wrong) m_retire(m_out_kind);
                    m_busy = 0;
                end
            end else if (if_allowin) begin
                if (m_exc_on) begin a = m_exc_pc; k = 3; end
                else if (m_br_on && m_slot_seen) begin a = m_br_tgt; k = 2; end
                else begin a = m_next; k = m_br_on ? 1 : 0; end
                if (a[1:0] != 2'b00) begin
                    e_v = 1; e_pc = a; e_adel = 1;
                    m_halted = 1; m_exc_on = 0; m_br_on = 0;
                end else begin
                    e_req = 1; e_addr = a;
                    if (inst_addr_ok) begin
                        e_v = 1; e_pc = a; m_next = a + 32'd4; m_retire(k);
                    end else begin
                        m_busy = 1; m_out_addr = a; m_out_wrong = 0; m_out_kind = k;
                    end
                end
            end
        end
        s_req = inst_req; s_addr = inst_addr; s_v = to_if_valid;
        s_pc = to_if_pc; s_cancel = to_if_cancel; s_adel = to_if_adel;
        check("inst_req", {31'b0, inst_req}, {31'b0, e_req});
        if (e_req) check("inst_addr", inst_addr, e_addr);
        check("to_if_valid", {31'b0, to_if_valid}, {31'b0, e_v});
        if (e_v) begin
            check("to_if_pc", to_if_pc, e_pc);
            check("to_if_cancel", {31'b0, to_if_cancel}, {31'b0, e_cancel});
            check("to_if_adel", {31'b0, to_if_adel}, {31'b0, e_adel});
        end
    endtask

    // One clock: drive inputs just after posedge, compare at negedge, advance past posedge.
    task automatic step(input logic exc, input logic [31:0] epc, input logic bv,
                        input logic [31:0] bt, input logic bds, input logic allow,
                        input logic aok);
        exception_like_now = exc; exception_like_now_pc = epc;
        br_valid = bv; br_target = bt; br_ds_issued = bds;
        if_allowin = allow; inst_addr_ok = aok;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic aok);
        step(0, '0, 0, '0, 0, 1, aok);
    endtask

    initial begin
        logic        exc, bv, bds, allow, aok;
        logic [31:0] epc, bt;

        reset = 1'b0;
        exception_like_now = 0; exception_like_now_pc = '0;
        br_valid = 0; br_target = '0; br_ds_issued = 0;
        if_allowin = 1; inst_addr_ok = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_inst_req", {31'b0, inst_req}, 32'd0);
        check("rst_valid", {31'b0, to_if_valid}, 32'd0);
        check("rst_cancel", {31'b0, to_if_cancel}, 32'd0);
        check("rst_adel", {31'b0, to_if_adel}, 32'd0);
        reset = 1'b1;

        // Sequential fetch from the reset vector.
        for (int i = 0; i < 3; i++) begin
            idle_step(1);
            check("t1_addr", s_addr, RESET_PC + 32'(4 * i));
            check("t1_cancel", {31'b0, s_cancel}, 32'd0);
        end

        // Exception arrives while a request waits for acceptance.
        step(1, 32'h0000_0100, 0, '0, 0, 1, 0);
        step(1, 32'h8000_0180, 0, '0, 0, 1, 0);
        check("t2_hold", s_addr, 32'h0000_0100);
        idle_step(0);
        check("t2_hold2", s_addr, 32'h0000_0100);
        idle_step(1);
        check("t2_cancel", {31'b0, s_cancel}, 32'd1);
        idle_step(1);
        check("t2_redirect", s_addr, 32'h8000_0180);

        // Branch with the delay slot still to fetch.
        step(1, 32'h0000_0200, 0, '0, 0, 1, 1);
        step(0, '0, 1, 32'h0000_0400, 0, 1, 1);
        check("t3_ds_pc", s_pc, 32'h0000_0204);
        check("t3_ds_cancel", {31'b0, s_cancel}, 32'd0);
        idle_step(1);
        check("t3_target", s_pc, 32'h0000_0400);

        // Branch after the delay slot, wrong-path request outstanding.
        step(1, 32'h0000_0200, 0, '0, 0, 1, 1);
        idle_step(1);
        idle_step(0);
        step(0, '0, 1, 32'h0000_0400, 1, 1, 0);
        check("t4_hold", s_addr, 32'h0000_0208);
        idle_step(1);
        check("t4_cancel", {31'b0, s_cancel}, 32'd1);
        idle_step(1);
        check("t4_target", s_pc, 32'h0000_0400);

        // Misaligned branch target raises AdEL and halts until cp0 redirects.
        step(0, '0, 1, 32'h0000_0402, 1, 1, 1);
        check("t5_no_req", {31'b0, s_req}, 32'd0);
        check("t5_adel", {31'b0, s_adel}, 32'd1);
        check("t5_pc", s_pc, 32'h0000_0402);
        idle_step(1);
        check("t5_halt", {31'b0, s_req}, 32'd0);
        step(1, 32'h8000_0180, 0, '0, 0, 1, 1);
        idle_step(1);
        check("t5_resume", s_addr, 32'h8000_0180);

        // Reset asserted while a request is outstanding.
        idle_step(0);
        reset = 1'b0;
        #1;
        check("t6_req_drop", {31'b0, inst_req}, 32'd0);
        check("t6_valid_drop", {31'b0, to_if_valid}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_step(1);
        check("t6_restart", s_addr, RESET_PC);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            exc   = ($urandom_range(0, 24) == 0);
            epc   = 32'h8000_0000 + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 19) == 0) epc[1:0] = 2'b10;
            bv    = !m_br_on && !m_exc_on && !m_halted && ($urandom_range(0, 7) == 0);
            bt    = 32'h0000_1000 + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 11) == 0) bt[1:0] = 2'b01;
            bds   = 1'($urandom_range(0, 1));
            allow = ($urandom_range(0, 3) != 0);
            aok   = 1'($urandom_range(0, 1));
            step(exc, epc, bv, bt, bds, allow, aok);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
